// File: rtl/mac_array_ctrl.sv
// Sequencer for the matrix-vector MAC array: fetches rows plus vector into FIFOs, streams them into the MACs.
// Optional build macro ROW_SKEW_EN skews per-row A reads and MAC enables for a systolic B operand.
module mac_array_ctrl #(
    parameter int              NUM_ROWS  = 8,
    parameter int              VEC_LEN   = 8,
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clr,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                mem_readdatavalid,
    input  logic                mem_waitrequest,
    output logic [NUM_ROWS-1:0] a_fifo_wren,
    output logic                b_fifo_wren,
    output logic [DATA_W-1:0]   fifo_wdata,
    output logic [NUM_ROWS-1:0] a_fifo_rden,
    output logic                b_fifo_rden,
    output logic [NUM_ROWS-1:0] mac_en,
    output logic                mac_clr,
    output logic                busy,
    output logic                done
);

    localparam int IW    = $clog2(NUM_ROWS + 1);
    localparam int SW    = $clog2(VEC_LEN + NUM_ROWS + 1);
    localparam int BYTES = DATA_W / 8;
`ifdef ROW_SKEW_EN
    localparam int COMPUTE_LEN = VEC_LEN + NUM_ROWS;
`else
    localparam int COMPUTE_LEN = VEC_LEN + 1;
`endif

    typedef enum logic [2:0] {IDLE, REQ, WAIT, COMPUTE, FLUSH, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [SW-1:0] step;
    logic          rd_base;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        mem_read    = 1'b0;
        mem_address = '0;
        busy        = 1'b0;
        done        = 1'b0;
        rd_base     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !clr) state_nxt = REQ;
            end
            REQ: begin
                mem_read    = 1'b1;
                mem_address = BASE_ADDR + ADDR_W'(idx) * ADDR_W'(BYTES);
                busy        = 1'b1;
                if (!mem_waitrequest) state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (mem_readdatavalid)
                    state_nxt = (idx == IW'(NUM_ROWS)) ? COMPUTE : REQ;
            end
            COMPUTE: begin
                busy    = 1'b1;
                rd_base = (step < SW'(VEC_LEN));
                if (step == SW'(COMPUTE_LEN - 1)) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (clr) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word index and compute step counters
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            step <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !clr) idx <= '0;
                end
                WAIT: begin
                    if (mem_readdatavalid) begin
                        idx  <= idx + IW'(1);
                        step <= '0;
                    end
                end
                COMPUTE: step <= step + SW'(1);
                default: ;
            endcase
        end
    end

    // FIFO write side and accumulator clear; only WAIT ever writes, so late read data is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            a_fifo_wren <= '0;
            b_fifo_wren <= 1'b0;
            fifo_wdata  <= '0;
            mac_clr     <= 1'b0;
        end else begin
            a_fifo_wren <= '0;
            b_fifo_wren <= 1'b0;
            mac_clr     <= ((state == IDLE) && (clr || start)) || ((state == DONE) && clr);
            if ((state == WAIT) && mem_readdatavalid) begin
                fifo_wdata <= mem_readdata;
                if (idx < IW'(NUM_ROWS)) a_fifo_wren <= NUM_ROWS'(1) << idx;
                else                     b_fifo_wren <= 1'b1;
            end
        end
    end

    assign b_fifo_rden = rd_base;

`ifdef ROW_SKEW_EN
    // rd_dly[i] is rd_base delayed i+1 cycles: row i reads i cycles late and accumulates one after that
    logic [NUM_ROWS-1:0] rd_dly;

    always_ff @(posedge clk) begin
        if (rst) rd_dly <= '0;
        else     rd_dly <= {rd_dly[NUM_ROWS-2:0], rd_base};
    end

    assign a_fifo_rden = {rd_dly[NUM_ROWS-2:0], rd_base};
    assign mac_en      = rd_dly;
`else
    assign a_fifo_rden = {NUM_ROWS{rd_base}};

    // FIFO read latency is one cycle, so accumulate one cycle after the read
    always_ff @(posedge clk) begin
        if (rst) mac_en <= '0;
        else     mac_en <= a_fifo_rden;
    end
`endif

endmodule
